// File: rtl/two_power_mod_radix_if.sv
// Request/result bundle for two_power_mod_radix; i_abort exists only when
// TWO_POWER_MOD_ABORT_EN is defined.
interface two_power_mod_radix_if #(
  parameter int MOD_W = 256,
  parameter int POW_W = 32,
  parameter int TAG_W = 4
);
  logic             i_valid;
  logic             i_ready;
  logic [POW_W-1:0] i_power;
  logic [MOD_W-1:0] i_modulus;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             o_ready;
  logic [MOD_W-1:0] o_out;
  logic [TAG_W-1:0] o_tag;
  logic             o_err;
`ifdef TWO_POWER_MOD_ABORT_EN
  logic             i_abort;
`endif

  modport slave (
`ifdef TWO_POWER_MOD_ABORT_EN
    input  i_abort,
`endif
    input  i_valid, i_power, i_modulus, i_tag, o_ready,
    output i_ready, o_valid, o_out, o_tag, o_err
  );

  modport master (
`ifdef TWO_POWER_MOD_ABORT_EN
    output i_abort,
`endif
    output i_valid, i_power, i_modulus, i_tag, o_ready,
    input  i_ready, o_valid, o_out, o_tag, o_err
  );
endinterface

// File: rtl/two_power_mod_radix.sv
// 2^power mod modulus by repeated modular doubling, STEP doublings per cycle.
// Optional abort input enabled by defining TWO_POWER_MOD_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for a request, i_ready=1
// RUN   | retiring min(STEP, remaining) doublings per cycle
// DONE  | result presented on o_valid, held until o_ready
module two_power_mod_radix #(
  parameter int MOD_W = 256,
  parameter int POW_W = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  two_power_mod_radix_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [MOD_W:0]   res, res_nxt, step_r;
  logic [MOD_W:0]   mod_r, mod_nxt;
  logic [POW_W-1:0] rem, rem_nxt;
  logic [TAG_W-1:0] tag_r, tag_nxt;
  logic             err_r, err_nxt;
  logic             abort;
  logic             accept;

`ifdef TWO_POWER_MOD_ABORT_EN
  assign abort = bus.i_abort && (state != IDLE);
`else
  assign abort = 1'b0;
`endif

  // abort outranks a same-cycle accept, so it also masks i_ready in DONE
  assign bus.i_ready = (state == IDLE) || ((state == DONE) && bus.o_ready && !abort);
  assign accept      = bus.i_valid && bus.i_ready;

  assign bus.o_valid = (state == DONE);
  assign bus.o_out   = res[MOD_W-1:0];
  assign bus.o_tag   = tag_r;
  assign bus.o_err   = err_r;

  // one extra bit keeps 2r from overflowing; r < modulus makes one subtract enough
  always_comb begin
    step_r = res;
    for (int k = 0; k < STEP; k++) begin
      if (POW_W'(k) < rem) begin
        step_r = step_r << 1;
        if (step_r >= mod_r) step_r = step_r - mod_r;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    mod_nxt   = mod_r;
    rem_nxt   = rem;
    tag_nxt   = tag_r;
    err_nxt   = err_r;
    case (state)
      IDLE: ;
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          res_nxt = step_r;
          if (rem <= POW_W'(STEP)) begin
            rem_nxt   = '0;
            state_nxt = DONE;
          end else begin
            rem_nxt = rem - POW_W'(STEP);
          end
        end
      end
      DONE: begin
        if (abort)            state_nxt = IDLE;
        else if (bus.o_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      mod_nxt = {1'b0, bus.i_modulus};
      rem_nxt = bus.i_power;
      tag_nxt = bus.i_tag;
      err_nxt = (bus.i_modulus == '0);
      res_nxt = (bus.i_modulus <= MOD_W'(1)) ? '0 : (MOD_W+1)'(1);
      // trivial cases finish without any doubling cycles
      if (bus.i_power == '0 || bus.i_modulus <= MOD_W'(1)) state_nxt = DONE;
      else                                                 state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      res   <= '0;
      mod_r <= '0;
      rem   <= '0;
      tag_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
      mod_r <= mod_nxt;
      rem   <= rem_nxt;
      tag_r <= tag_nxt;
      err_r <= err_nxt;
    end
  end

endmodule
